pipe4_hazard_ctrl: RTL

Central pipeline controller for the 4-stage (IF, ID, EX, WB) 32-bit core.
- Tracks destination registers of the instructions in EX and WB in a small scoreboard.
- Drives operand-forwarding selects, load-use and multi-cycle-EX stalls, and branch flushes.
- Sits beside the datapath: takes decode info from ID and branch resolution from EX, and returns stall, flush and bubble controls to the PC, IF/ID and ID/EX registers.

---
 rtl/pipe4_hazard_ctrl_if.sv | 48 ++++
 rtl/pipe4_hazard_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pipe4_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe4_hazard_ctrl_if
//  Description : Decode/branch inputs and stall/flush/forwarding controls
//                exchanged between the 4-stage datapath and its hazard
//                controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe4_hazard_ctrl_if #(
    parameter int RA_W = 5
);
    // Decode information from ID and branch resolution from EX
    logic            id_valid;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic [RA_W-1:0] id_rd;
    logic            id_we;
    logic            id_load;
    logic            id_multi;
    logic            ex_branch_taken;

    // Control returned to the PC, IF/ID and ID/EX registers
    logic            pc_stall;
    logic            ifid_stall;
    logic            ifid_flush;
    logic            idex_bubble;
    logic [1:0]      fwd_a_sel;
    logic [1:0]      fwd_b_sel;
    logic            ex_busy;
    logic            ex_done;

    // Datapath side
    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_we, id_load, id_multi,
               ex_branch_taken,
        input  pc_stall, ifid_stall, ifid_flush, idex_bubble,
               fwd_a_sel, fwd_b_sel, ex_busy, ex_done
    );

    // Controller side
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_we, id_load, id_multi,
               ex_branch_taken,
        output pc_stall, ifid_stall, ifid_flush, idex_bubble,
               fwd_a_sel, fwd_b_sel, ex_busy, ex_done
    );
endinterface
`default_nettype wire

// File: rtl/pipe4_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe4_hazard_ctrl
//  Description : Hazard controller for the IF/ID/EX/WB core. Keeps a two-entry
//                destination scoreboard (EX, WB), drives operand forwarding,
//                load-use and multi-cycle-EX stalls and taken-branch flushes.
//                Build option HAZARD_FWD_EN: when defined, operands are
//                forwarded from EX/WB; when undefined, every EX/WB dependency
//                is resolved by interlocking and the selects stay 00.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe4_hazard_ctrl #(
    parameter int RA_W         = 5,
    parameter int MULTI_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    pipe4_hazard_ctrl_if.slave  bus
);

    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_MULTI = 1'b1;
    localparam logic [3:0] c_CNT_LOAD = 4'(MULTI_CYCLES - 1);

    // FSM and registered outputs
    logic [0:0]      r_state;
    logic [3:0]      r_cnt;
    logic            r_ex_busy;
    logic            r_ex_done;

    // Scoreboard: destination of the instructions now in EX and WB
    logic [RA_W-1:0] r_ex_rd;
    logic            r_ex_we;
    logic            r_ex_load;
    logic [RA_W-1:0] r_wb_rd;
    logic            r_wb_we;

    // Hazard decode
    logic            w_in_multi;
    logic            w_ex_hit_a;
    logic            w_ex_hit_b;
    logic            w_wb_hit_a;
    logic            w_wb_hit_b;
    logic            w_load_use;
    logic            w_interlock;
    logic            w_flush;
    logic            w_dep_stall;
    logic            w_enter_multi;
    logic            w_id_writes;
    logic [1:0]      w_fwd_a;
    logic [1:0]      w_fwd_b;

    assign w_in_multi = (r_state == c_ST_MULTI);

    // An entry only ever holds we=1 for a nonzero rd, so the r0 test on the
    // source side is what keeps r0 reads from matching.
    assign w_ex_hit_a = r_ex_we && (r_ex_rd == bus.id_rs1) && (bus.id_rs1 != '0);
    assign w_ex_hit_b = r_ex_we && (r_ex_rd == bus.id_rs2) && (bus.id_rs2 != '0);
    assign w_wb_hit_a = r_wb_we && (r_wb_rd == bus.id_rs1) && (bus.id_rs1 != '0);
    assign w_wb_hit_b = r_wb_we && (r_wb_rd == bus.id_rs2) && (bus.id_rs2 != '0);

    // A load in EX has no result yet; its consumer must wait one cycle.
    assign w_load_use = bus.id_valid && r_ex_load && (w_ex_hit_a || w_ex_hit_b);

`ifdef HAZARD_FWD_EN
    assign w_interlock = 1'b0;

    // Operand source select: EX result beats WB result, loads in EX excluded
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (bus.id_valid) begin
            if (w_ex_hit_a && !r_ex_load) begin
                w_fwd_a = 2'b01;
            end else if (w_wb_hit_a) begin
                w_fwd_a = 2'b10;
            end
            if (w_ex_hit_b && !r_ex_load) begin
                w_fwd_b = 2'b01;
            end else if (w_wb_hit_b) begin
                w_fwd_b = 2'b10;
            end
        end
    end
`else
    // Without a bypass network any in-flight producer blocks the reader.
    assign w_interlock = bus.id_valid &&
                         (w_ex_hit_a || w_ex_hit_b || w_wb_hit_a || w_wb_hit_b);
    assign w_fwd_a     = 2'b00;
    assign w_fwd_b     = 2'b00;
`endif

    // Priority: multi-cycle hold, then branch flush, then dependency stall
    assign w_flush       = !w_in_multi && bus.ex_branch_taken;
    assign w_dep_stall   = !w_in_multi && !w_flush && (w_load_use || w_interlock);
    assign w_enter_multi = !w_in_multi && !w_flush && !w_dep_stall &&
                           bus.id_valid && bus.id_multi;
    assign w_id_writes   = bus.id_valid && bus.id_we && (bus.id_rd != '0);

    assign bus.pc_stall    = w_in_multi || w_dep_stall;
    assign bus.ifid_stall  = w_in_multi || w_dep_stall;
    assign bus.ifid_flush  = w_flush;
    assign bus.idex_bubble = w_in_multi || w_flush || w_dep_stall;
    assign bus.fwd_a_sel   = w_fwd_a;
    assign bus.fwd_b_sel   = w_fwd_b;
    assign bus.ex_busy     = r_ex_busy;
    assign bus.ex_done     = r_ex_done;

    // RUN/MULTI sequencing. ex_busy and ex_done are registered from the
    // transition so the final EX cycle (state back in RUN) still shows busy
    // together with the done pulse while the stalls are already released.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_RUN;
            r_cnt     <= 4'd0;
            r_ex_busy <= 1'b0;
            r_ex_done <= 1'b0;
        end else begin
            case (r_state)
                c_ST_MULTI: begin
                    r_ex_busy <= 1'b1;
                    if (r_cnt == 4'd1) begin
                        r_state   <= c_ST_RUN;
                        r_cnt     <= 4'd0;
                        r_ex_done <= 1'b1;
                    end else begin
                        r_cnt     <= r_cnt - 4'd1;
                        r_ex_done <= 1'b0;
                    end
                end
                default: begin
                    r_ex_done <= 1'b0;
                    if (w_enter_multi) begin
                        r_state   <= c_ST_MULTI;
                        r_cnt     <= c_CNT_LOAD;
                        r_ex_busy <= 1'b1;
                    end else begin
                        r_ex_busy <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Scoreboard shift: held in MULTI (WB drains), emptied on bubble/flush
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_rd   <= '0;
            r_ex_we   <= 1'b0;
            r_ex_load <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_we   <= 1'b0;
        end else if (w_in_multi) begin
            r_wb_rd <= '0;
            r_wb_we <= 1'b0;
        end else begin
            r_wb_rd <= r_ex_rd;
            r_wb_we <= r_ex_we;
            if (w_flush || w_dep_stall) begin
                r_ex_rd   <= '0;
                r_ex_we   <= 1'b0;
                r_ex_load <= 1'b0;
            end else begin
                r_ex_rd   <= bus.id_rd;
                r_ex_we   <= w_id_writes;
                r_ex_load <= bus.id_valid && bus.id_load;
            end
        end
    end

endmodule
`default_nettype wire
